// File: rtl/block_serial_sub.sv
// Block-serial subtractor: resolves VALENCY bits per cycle with in-block borrow lookahead.
// Optional signed-overflow output OVF is compiled in with `define BLOCK_SERIAL_SUB_OVERFLOW_EN.
module block_serial_sub #(
  parameter int SIZE    = 16,
  parameter int VALENCY = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [SIZE:1] A,
  input  logic [SIZE:1] B,
  input  logic          BIN,
  output logic          BUSY,
  output logic          DONE,
  output logic [SIZE:1] DIFF,
  output logic          BOUT
`ifdef BLOCK_SERIAL_SUB_OVERFLOW_EN
  ,
  output logic          OVF
`endif
);

  localparam int NBLK  = SIZE / VALENCY;
  localparam int CNT_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   brw;
  logic [SIZE-1:0]        a_r, b_r, acc;
  logic [VALENCY-1:0]     blk_diff;
  logic                   blk_bout;
  logic                   last_blk;
  logic                   launch;
  logic [SIZE+VALENCY-1:0] acc_cat;
  logic [SIZE-1:0]        acc_nxt;

  // Borrow lookahead over one block: generate where a=0,b=1; propagate where a==b.
  function automatic logic [VALENCY:0] blk_sub(input logic [VALENCY-1:0] a,
                                               input logic [VALENCY-1:0] b,
                                               input logic               bin);
    logic [VALENCY-1:0] g, p, d;
    logic [VALENCY:0]   c;
    g    = ~a & b;
    p    = ~(a ^ b);
    c[0] = bin;
    for (int i = 0; i < VALENCY; i++) c[i+1] = g[i] | (p[i] & c[i]);
    d = ~p ^ c[VALENCY-1:0];
    return {c[VALENCY], d};
  endfunction

  // Operands shift right each RUN cycle, so the active block is always the low VALENCY bits.
  assign {blk_bout, blk_diff} = blk_sub(a_r[VALENCY-1:0], b_r[VALENCY-1:0], brw);
  assign acc_cat  = {blk_diff, acc};
  assign acc_nxt  = acc_cat[SIZE+VALENCY-1:VALENCY];
  assign last_blk = (cnt == CNT_W'(NBLK - 1));
  assign launch   = (state != RUN) && START;
  assign BUSY     = (state == RUN);
  assign DONE     = (state == FIN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, FIN: state_nxt = START ? RUN : IDLE;
      RUN:       if (last_blk) state_nxt = FIN;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      brw   <= 1'b0;
      DIFF  <= '0;
      BOUT  <= 1'b0;
`ifdef BLOCK_SERIAL_SUB_OVERFLOW_EN
      OVF   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (launch) begin
        cnt <= '0;
        brw <= BIN;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        brw <= blk_bout;
        if (last_blk) begin
          DIFF <= acc_nxt;
          BOUT <= blk_bout;
`ifdef BLOCK_SERIAL_SUB_OVERFLOW_EN
          // On the last block the low operand bits are the original sign bits.
          OVF  <= (a_r[VALENCY-1] & ~b_r[VALENCY-1] & ~blk_diff[VALENCY-1]) |
                  (~a_r[VALENCY-1] & b_r[VALENCY-1] & blk_diff[VALENCY-1]);
`endif
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (launch) begin
      a_r <= A;
      b_r <= B;
    end else if (state == RUN) begin
      a_r <= a_r >> VALENCY;
      b_r <= b_r >> VALENCY;
      acc <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_block_serial_sub.sv
// Self-checking bench for block_serial_sub (SIZE=16, VALENCY=4): vector table,
// corner-case sequences and randomized operands against an arithmetic model.
module tb_block_serial_sub;

  localparam int SIZE = 16;

  logic            CLK;
  logic            RST_N;
  logic            START;
  logic [SIZE:1]   A, B;
  logic            BIN;
  logic            BUSY, DONE;
  logic [SIZE:1]   DIFF;
  logic            BOUT;
`ifdef BLOCK_SERIAL_SUB_OVERFLOW_EN
  logic            OVF;
`endif

  block_serial_sub #(.SIZE(SIZE), .VALENCY(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .BIN   (BIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .DIFF  (DIFF),
    .BOUT  (BOUT)
`ifdef BLOCK_SERIAL_SUB_OVERFLOW_EN
    ,
    .OVF   (OVF)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] diff, output logic bout, output logic ovf);
    int u, s;
    u    = int'(a) - int'(b) - int'(bin);
    s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
    diff = u[15:0];
    bout = (u < 0);
    ovf  = (s > 32767) || (s < -32768);
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic bin);
    A = a; B = b; BIN = bin; START = 1'b1;
  endtask

  // Called on the negedge after the START-sampling edge; returns edges until DONE.
  task automatic wait_done(output int lat, output int busyc);
    lat = 0; busyc = 0;
    while (DONE !== 1'b1 && lat < 40) begin
      if (BUSY === 1'b1) busyc++;
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output int lat, output int busyc);
    @(negedge CLK);
    launch(a, b, bin);
    @(negedge CLK);
    START = 1'b0;
    wait_done(lat, busyc);
  endtask

  task automatic check_result(input string tag, input logic [15:0] ed, input logic eb,
                              input logic eo);
    check({tag, "_diff"}, 32'(DIFF), 32'(ed));
    check({tag, "_bout"}, 32'(BOUT), 32'(eb));
`ifdef BLOCK_SERIAL_SUB_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(OVF), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unexpected X in overflow expectation");
`endif
  endtask

  initial begin
    int lat, busyc, dones;
    logic [15:0] ra, rb, ed, cap_d;
    logic rbin, eb, eo, cap_b;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[6] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    RST_N = 1'b1; START = 1'b0; A = '0; B = '0; BIN = 1'b0;
    #2 RST_N = 1'b0;
    #2;
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_diff", 32'(DIFF), 0);
    check("rst_bout", 32'(BOUT), 0);
`ifdef BLOCK_SERIAL_SUB_OVERFLOW_EN
    check("rst_ovf", 32'(OVF), 0);
`endif
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, busyc);
      check($sformatf("vec%0d_latency", i), 32'(lat), 4);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busyc), 4);
      check_result($sformatf("vec%0d", i), vecs[i].diff, vecs[i].bout, vecs[i].ovf);
      @(negedge CLK);
      check($sformatf("vec%0d_done_width", i), 32'(DONE), 0);
    end

    // Busy-ignore: second request and operand changes during RUN must not disturb the result
    @(negedge CLK);
    launch(16'h00FF, 16'h000F, 1'b0);
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    launch(16'hFFFF, 16'h0000, 1'b0);
    @(negedge CLK);
    START = 1'b0; A = 16'h1234; B = 16'h0234;
    check("ign_busy_mid", 32'(BUSY), 1);
    dones = 0; cap_d = '0; cap_b = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (DONE === 1'b1) begin
        dones++; cap_d = DIFF; cap_b = BOUT;
      end
      @(negedge CLK);
    end
    check("ign_done_pulses", 32'(dones), 1);
    check("ign_diff", 32'(cap_d), 32'h00F0);
    check("ign_bout", 32'(cap_b), 0);

    // Back-to-back: START raised during FIN goes straight to RUN
    run_op(16'h0100, 16'h0001, 1'b0, lat, busyc);
    check("b2b_first_diff", 32'(DIFF), 32'h00FF);
    launch(16'h0010, 16'h0001, 1'b0);
    @(negedge CLK);
    START = 1'b0;
    check("b2b_no_idle_busy", 32'(BUSY), 1);
    check("b2b_no_idle_done", 32'(DONE), 0);
    wait_done(lat, busyc);
    check("b2b_latency", 32'(lat), 4);
    check("b2b_diff", 32'(DIFF), 32'h000F);
    check("b2b_bout", 32'(BOUT), 0);

    // Reset on the 2nd RUN cycle aborts the operation
    @(negedge CLK);
    launch(16'hFFFF, 16'h0001, 1'b0);
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("rmid_busy", 32'(BUSY), 0);
    check("rmid_done", 32'(DONE), 0);
    check("rmid_diff", 32'(DIFF), 0);
    check("rmid_bout", 32'(BOUT), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (DONE === 1'b1 || BUSY === 1'b1) dones++;
      @(negedge CLK);
    end
    check("rmid_no_done_after", 32'(dones), 0);
    // START presented together with reset release is taken at the first edge
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    launch(16'h1234, 16'h0234, 1'b0);
    @(negedge CLK);
    START = 1'b0;
    check("rrel_busy", 32'(BUSY), 1);
    wait_done(lat, busyc);
    check("rrel_latency", 32'(lat), 4);
    check("rrel_diff", 32'(DIFF), 32'h1000);

    // Randomized operands against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom_range(0, 1));
      if (n % 8 == 0) ra = 16'h8000;
      if (n % 8 == 1) rb = ra;
      model(ra, rb, rbin, ed, eb, eo);
      run_op(ra, rb, rbin, lat, busyc);
      check($sformatf("rnd%0d_latency", n), 32'(lat), 4);
      check_result($sformatf("rnd%0d", n), ed, eb, eo);
    end

    @(negedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/block_serial_sub.md
BLOCK_SERIAL_SUB -- requirements
Module: block_serial_sub

Interface
REQ-001 SHALL have parameter SIZE, default 16: operand width in bits.
REQ-002 SHALL have parameter VALENCY, default 4: bits resolved per cycle by the in-block borrow-lookahead; SIZE SHALL be an integer multiple of VALENCY, and VALENCY SHALL be one of 2, 4 or 8.
REQ-003 SHALL have a single clock and an asynchronous active-low reset.
REQ-004 Port list:
- CLK  in  1  clock; rising edge active.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request; sampled only when BUSY=0.
- A  in  [SIZE:1]  minuend; bit 1 is the LSB.
- B  in  [SIZE:1]  subtrahend.
- BIN  in  1  borrow-in.
- BUSY  out  1  high while an operation is in progress.
- DONE  out  1  one-cycle completion pulse.
- DIFF  out  [SIZE:1]  result.
- BOUT  out  1  borrow-out.
- OVF  out  1  signed overflow; present only per REQ-020.

Function
REQ-005 SHALL compute DIFF = (A - B - BIN) mod 2^SIZE, with BOUT=1 exactly when A < B + BIN (unsigned comparison).
REQ-006 SHALL implement three states:
- IDLE
- RUN
- FIN
REQ-007 In IDLE or FIN, a START=1 sampled at a rising edge SHALL:
- latch A, B and BIN into internal registers;
- clear the block counter;
- enter RUN.
REQ-008 In RUN, each rising edge SHALL resolve the block counter's VALENCY-bit block, LSB block first:
- per-bit generate = ~a & b;
- per-bit propagate = ~(a ^ b);
- in-block lookahead from the registered borrow;
- store the block difference bits internally;
- update the borrow register to the block borrow-out;
- increment the counter.
REQ-009 The edge that resolves the last block, block SIZE/VALENCY-1, SHALL:
- load DIFF and BOUT from the completed internal result;
- enter FIN.
REQ-010 Latency: DONE SHALL be high in the cycle after the SIZE/VALENCY-th rising edge following the edge that sampled START (4 cycles at the default parameters).
REQ-011 Output levels by state:
- BUSY SHALL be 1 exactly in RUN.
- DONE SHALL be 1 exactly in FIN.
REQ-012 FIN SHALL return to IDLE on the next edge unless START=1, in which case REQ-007 applies (back-to-back operation, no idle cycle).
REQ-013 START, A, B and BIN SHALL be ignored while BUSY=1; operands already latched SHALL NOT change mid-operation.
REQ-014 DIFF, BOUT (and OVF) SHALL hold their last loaded values until the next completion or reset; they SHALL never show partial results.
REQ-015 SHALL use no combinational path from any input to any output.

Reset
REQ-016 RST_N=0 SHALL immediately, independent of CLK:
- force the state to IDLE;
- clear the counter and the borrow register;
- drive BUSY=0, DONE=0, DIFF=0, BOUT=0 and OVF=0.
REQ-017 Reset asserted during RUN SHALL abort the operation; no DONE pulse SHALL follow for the aborted operation.
REQ-018 After RST_N deasserts, the block SHALL accept START at the first rising edge.

Configuration
REQ-019 Macro BLOCK_SERIAL_SUB_OVERFLOW_EN SHALL select whether the signed overflow feature is compiled in.
REQ-020 With BLOCK_SERIAL_SUB_OVERFLOW_EN defined:
- port OVF SHALL exist;
- OVF SHALL load alongside DIFF with A[SIZE] & ~B[SIZE] & ~DIFF[SIZE] | ~A[SIZE] & B[SIZE] & DIFF[SIZE], using the latched operands.
REQ-021 Without BLOCK_SERIAL_SUB_OVERFLOW_EN, port OVF and its register SHALL be absent; all other behaviour SHALL be unchanged.

Verification (SIZE=16, VALENCY=4)
REQ-022 Basic operation: A=0x1234, B=0x0234, BIN=0, START for 1 cycle -> DIFF=0x1000, BOUT=0; DONE high for exactly 1 cycle, 4 cycles after START is sampled; BUSY high for 4 cycles.
REQ-023 Full borrow ripple: A=0x0000, B=0x0001, BIN=0 -> DIFF=0xFFFF, BOUT=1; borrow crosses all 4 blocks.
REQ-024 Borrow-in and overflow:
- A=0x0005, B=0x0005, BIN=1 -> DIFF=0xFFFF, BOUT=1, OVF=0.
- A=0x8000, B=0x0001, BIN=0 -> DIFF=0x7FFF, BOUT=0, OVF=1 (macro defined).
REQ-025 Busy-ignore: START with A=0x00FF, B=0x000F; then START with A=0xFFFF, B=0 during RUN, and operands changed mid-RUN -> first result DIFF=0x00F0; second request ignored; one DONE pulse.
REQ-026 Back-to-back: START held high across FIN with A=0x0010, B=0x0001 -> second operation enters RUN directly from FIN; DIFF=0x000F 4 cycles after FIN; no IDLE cycle in between.
REQ-027 Reset mid-operation: RST_N=0 asserted on the 2nd RUN cycle -> BUSY, DONE, DIFF and BOUT read 0 immediately; no DONE pulse follows; a new START after release completes normally.
